// File: rtl/mem_pkg.sv
// Shared definitions for the instruction fetch path and its memory interface.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StSquash
  } fetch_state_e;

  localparam int unsigned BURST_WORDS    = 4;
  localparam int unsigned BEAT_W         = $clog2(BURST_WORDS);
  localparam logic [1:0]  ACCESS_SIZE_4W = 2'd1;
  localparam logic [31:0] BURST_BYTES    = 32'(BURST_WORDS * 4);

endpackage

// File: rtl/insn_fifo.sv
// Instruction buffer: DEPTH entries of {pc, insn}, head always visible, flush empties it.
module insn_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign valid  = (count_q != '0);
  assign do_pop = pop & valid;
  assign head   = mem_q[rd_q];
  assign count  = count_q;

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues 4-word burst reads into a buffer, handles redirects by flushing.
module fetch_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        insn_ready,
  output logic        insn_valid,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_access_size,
  output logic        mem_rd_wr,
  output logic        mem_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy
);

  import mem_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              req, push, pop, last_beat, room;
  logic [63:0]       push_data, head;
  logic [CW-1:0]     count;

  assign last_beat = (beat_q == BEAT_W'(BURST_WORDS - 1));
  // A whole burst must fit before it is requested, so the buffer can never overflow.
  assign room      = (count <= CW'(DEPTH - BURST_WORDS));
  assign push_data = {addr_q + 32'({beat_q, 2'b00}), mem_rdata};
  assign pop       = insn_ready & ~redirect_valid;

  assign mem_enable      = req;
  assign mem_addr        = addr_d;
  assign mem_access_size = ACCESS_SIZE_4W;
  assign mem_rd_wr       = 1'b1;
  assign insn_pc         = head[63:32];
  assign insn            = head[31:0];

  // Next-state, request and push decisions; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    beat_d     = beat_q;
    req        = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // reset_n gating keeps the strobe low while reset is held.
        if (reset_n && !redirect_valid && !mem_busy && room) begin
          req        = 1'b1;
          state_d    = StBurst;
          fetch_pc_d = fetch_pc_q + BURST_BYTES;
          beat_d     = '0;
        end
      end
      StBurst: begin
        push   = ~redirect_valid;
        beat_d = beat_q + BEAT_W'(1);
        if (last_beat) begin
          state_d = StIdle;
        end else if (redirect_valid) begin
          state_d = StSquash;
        end
      end
      StSquash: begin
        beat_d = beat_q + BEAT_W'(1);
        if (last_beat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    // addr_q doubles as the burst base while beats are arriving.
    addr_d = req ? fetch_pc_q : addr_q;
  end

  // State, fetch pointer, burst base and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= BASE_ADDR;
      addr_q     <= BASE_ADDR;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
    end
  end

  insn_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_insn_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .valid    (insn_valid),
    .count    (count)
  );

endmodule
